down_counter_5bit: RTL and testbench
====================================

Name: down_counter_5bit

Overview:
Loadable 5-bit down-counter/timer with terminal-count signalling. It is the count-down counterpart of the team's up-counter. Software or upstream logic loads a start value, and the block decrements on each enabled cycle. At expiry it emits a one-cycle `done` pulse, then either stops or auto-reloads. It is used as an interval timer and as a delay generator next to the up-counter in the counter subsystem.

Parameters:
WIDTH, 5, counter width in bits; all count/value ports are WIDTH wide.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  load request; samples load_val this cycle
load_val  input  WIDTH  start value; also captured as the reload value
en  input  1  count enable; decrement allowed when 1
auto_reload  input  1  1 = restart from the reload value at expiry; 0 = stop at 0
count  output  WIDTH  current count, registered
busy  output  1  1 while in RUN state, registered
done  output  1  one-cycle pulse on expiry, registered

Behaviour:
- Reset, asynchronous on rst_n low: state = IDLE, count = 0, reload register = 0, busy = 0, done = 0. All outputs are held at these values while rst_n = 0. Reset mid-count aborts the count immediately; no done is produced.
- Single clock domain. All outputs are registered. No combinational path exists from any input to any output.
- State machine has two states: IDLE and RUN. busy = (state == RUN).
- Priority is fixed: load > en. This holds in every state.
- IDLE:
  - load = 1 with load_val != 0: count <= load_val, reload <= load_val, go to RUN.
  - load = 1 with load_val == 0: count <= 0, reload <= 0, stay in IDLE, done stays 0.
  - en has no effect in IDLE; count holds.
- RUN, load = 1: restart. count <= load_val, reload <= load_val, done <= 0. Next state is RUN if load_val != 0, otherwise IDLE. A load in the same cycle as expiry suppresses done.
- RUN, en = 0: count holds, done <= 0.
- RUN, en = 1, count > 1: count <= count - 1, done <= 0.
- RUN, en = 1, count == 1 (expiry):
  - done <= 1, so done is high in the cycle after the edge where count reaches 0 or reloads.
  - auto_reload = 0: count <= 0, go to IDLE.
  - auto_reload = 1: count <= reload, stay in RUN. Period = reload enabled cycles.
- auto_reload is sampled only at the expiry edge, so changing it mid-count is legal.
- done is never asserted on two consecutive cycles unless reload == 1 with auto_reload = 1 and en held high. In that case done stays high every cycle, which is legal.
- Wrap-around: count never decrements below 0. There is no underflow.
- Arithmetic is unsigned, WIDTH bits. The maximum start value is 2^WIDTH - 1, i.e. 31 at the default width.

Optional Feature:
Macro: DOWN_COUNTER_STICKY_EN
- Defined:
  - Adds input `done_clr` (1 bit) and output `done_flag` (1 bit, registered, reset 0).
  - done_flag sets on any cycle where done is set, and clears on done_clr.
  - If set and clear occur in the same cycle, set wins.
- Not defined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package `down_counter_pkg`:
  - state enum {IDLE, RUN}
  - default WIDTH constant = 5
- One sub-module, `dcnt_reg`: WIDTH-bit register with asynchronous active-low reset to 0 and a synchronous load enable. It is instantiated twice, once for count and once for reload.
- The FSM and next-count logic stay in the top module.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN with count = 9 → count = 0, busy = 0, done = 0 immediately (asynchronous); no done after release.
- One-shot: load 5, en = 1 continuously, auto_reload = 0 → count 5,4,3,2,1,0; done high exactly one cycle, coincident with count = 0; busy falls in that same cycle.
- Auto-reload: load 3, auto_reload = 1, en = 1 for 12 cycles → count 3,2,1,3,2,1,…; done pulses every 3 cycles, 4 pulses total; busy stays 1.
- Enable gating and priority:
  - load 4, toggle en 1,0,1,0 → count decrements only on en = 1 cycles.
  - load 7 asserted in the expiry cycle → count = 7, no done pulse.
- Boundaries:
  - load 0 → stays IDLE, no done.
  - load 31 with en held → done after exactly 31 cycles.
  - load 1 with auto_reload = 1 → done high every cycle.
- Sticky (with DOWN_COUNTER_STICKY_EN):
  - expiry → done_flag = 1 and holds.
  - done_clr in the same cycle as the next done → done_flag stays 1.
  - done_clr alone → done_flag = 0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter.
// Holds the FSM state encoding and the default counter width.
package down_counter_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter_5bit_reg.sv
// WIDTH-bit register for the down-counter.
// Async active-low reset to 0, synchronous load enable.
module dcnt_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Hold value; take i_d when load enable is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (i_ld)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/down_counter_5bit.sv
// Loadable down-counter/timer with one-cycle done pulse on expiry.
// Optional DOWN_COUNTER_STICKY_EN adds done_clr/done_flag.
module down_counter_5bit
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
`ifdef DOWN_COUNTER_STICKY_EN
  input  logic             done_clr,
  output logic             done_flag,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_cnt_ld;
  logic [WIDTH-1:0] w_cnt_d;
  logic             w_rl_ld;
  logic [WIDTH-1:0] w_reload;
  logic [WIDTH-1:0] w_count;
  logic             w_run;
  logic             w_last;

  assign w_run  = (r_state == RUN);
  assign w_last = (w_count == WIDTH'(1));

  dcnt_reg #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_cnt_ld),
    .i_d   (w_cnt_d),
    .o_q   (w_count)
  );

  dcnt_reg #(.WIDTH(WIDTH)) u_rld (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_rl_ld),
    .i_d   (load_val),
    .o_q   (w_reload)
  );

  // Next state, next count and done; load always wins over en.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_cnt_ld    = 1'b0;
    w_cnt_d     = load_val;
    w_rl_ld     = 1'b0;
    unique case (1'b1)
      load: begin
        w_cnt_ld    = 1'b1;
        w_rl_ld     = 1'b1;
        w_state_nxt = (load_val != '0) ? RUN : IDLE;
      end
      (!load && w_run && en && w_count > WIDTH'(1)): begin
        w_cnt_ld = 1'b1;
        w_cnt_d  = w_count - WIDTH'(1);
      end
      (!load && w_run && en && w_last): begin
        w_cnt_ld   = 1'b1;
        w_done_nxt = 1'b1;
        if (auto_reload) begin
          w_cnt_d = w_reload;
        end else begin
          w_cnt_d     = '0;
          w_state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  // State and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef DOWN_COUNTER_STICKY_EN
  logic r_flag;

  // Sticky expiry flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flag <= 1'b0;
    else if (w_done_nxt)
      r_flag <= 1'b1;
    else if (done_clr)
      r_flag <= 1'b0;
  end

  assign done_flag = r_flag;
`endif

  assign count = w_count;
  assign busy  = w_run;
  assign done  = r_done;

endmodule

// File: tb/tb_down_counter_5bit.sv
// Directed bench for down_counter_5bit with a scoreboard queue.
// Define DOWN_COUNTER_STICKY_EN to also exercise done_flag.
module tb_down_counter_5bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic       done_clr = 1'b0;
  logic       done_flag;
  logic [4:0] count;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [4:0] c;
    logic       b;
    logic       d;
    logic       f;
    logic       fc;
    string      tag;
  } exp_t;

  exp_t sb[$];

  down_counter_5bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
`ifdef DOWN_COUNTER_STICKY_EN
    .done_clr    (done_clr),
    .done_flag   (done_flag),
`endif
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

`ifndef DOWN_COUNTER_STICKY_EN
  assign done_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    x = sb.pop_front();
    checks++;
    assert (count === x.c) else begin
      fails++;
      $error("FAIL %s count observed=%0d expected=%0d", x.tag, count, x.c);
    end
    checks++;
    assert (busy === x.b) else begin
      fails++;
      $error("FAIL %s busy observed=%b expected=%b", x.tag, busy, x.b);
    end
    checks++;
    assert (done === x.d) else begin
      fails++;
      $error("FAIL %s done observed=%b expected=%b", x.tag, done, x.d);
    end
    if (x.fc) begin
      checks++;
      assert (done_flag === x.f) else begin
        fails++;
        $error("FAIL %s done_flag observed=%b expected=%b",
               x.tag, done_flag, x.f);
      end
    end
  endtask

  task automatic cyc(input logic ld, input logic [4:0] lv,
                     input logic e, input logic ar,
                     input logic [4:0] ec, input logic eb,
                     input logic ed, input string tag,
                     input logic fc = 1'b0, input logic ef = 1'b0);
    load = ld;
    load_val = lv;
    en = e;
    auto_reload = ar;
    sb.push_back('{c: ec, b: eb, d: ed, f: ef, fc: fc, tag: tag});
    @(posedge clk);
    #1;
    chk();
  endtask

  initial begin
    int ndone;
    logic [4:0] m;
    #2;
    sb.push_back('{c: 5'd0, b: 1'b0, d: 1'b0, f: 1'b0, fc: 1'b1,
                   tag: "reset"});
    chk();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // one-shot from 5
    cyc(1, 5, 1, 0, 5, 1, 0, "os_load");
    for (int k = 4; k >= 1; k--)
      cyc(0, 0, 1, 0, 5'(k), 1, 0, "os_dec");
    cyc(0, 0, 1, 0, 0, 0, 1, "os_expire");
    cyc(0, 0, 1, 0, 0, 0, 0, "os_after");

    // auto-reload period 3 for 12 cycles
    cyc(1, 3, 1, 1, 3, 1, 0, "ar_load");
    m = 5'd3;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      logic dx;
      dx = (m == 5'd1);
      m = dx ? 5'd3 : m - 5'd1;
      if (dx) ndone++;
      cyc(0, 0, 1, 1, m, 1, dx, "ar_run");
    end
    checks++;
    assert (ndone === 4) else begin
      fails++;
      $error("FAIL ar_pulses observed=%0d expected=4", ndone);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, "run_load0");

    // enable gating, then load during expiry
    cyc(1, 4, 0, 0, 4, 1, 0, "en_load");
    cyc(0, 0, 1, 0, 3, 1, 0, "en_on1");
    cyc(0, 0, 0, 0, 3, 1, 0, "en_off1");
    cyc(0, 0, 1, 0, 2, 1, 0, "en_on2");
    cyc(0, 0, 0, 0, 2, 1, 0, "en_off2");
    cyc(0, 0, 1, 0, 1, 1, 0, "en_on3");
    cyc(1, 7, 1, 0, 7, 1, 0, "prio_load");
    cyc(0, 0, 0, 0, 7, 1, 0, "prio_hold");
    cyc(1, 0, 0, 0, 0, 0, 0, "prio_stop");

    // load 0 from IDLE
    cyc(1, 0, 1, 0, 0, 0, 0, "ld0");
    cyc(0, 0, 1, 0, 0, 0, 0, "ld0_en");

    // max start value
    cyc(1, 31, 1, 0, 31, 1, 0, "max_load");
    for (int k = 1; k <= 30; k++)
      cyc(0, 0, 1, 0, 5'(31 - k), 1, 0, "max_dec");
    cyc(0, 0, 1, 0, 0, 0, 1, "max_expire");

    // reload 1: done every cycle
    cyc(1, 1, 1, 1, 1, 1, 0, "r1_load");
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 1, 1, 1, 1, "r1_run");
    cyc(1, 0, 0, 0, 0, 0, 0, "r1_stop");

    // asynchronous reset while running at 9
    cyc(1, 9, 0, 0, 9, 1, 0, "rst_load");
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{c: 5'd0, b: 1'b0, d: 1'b0, f: 1'b0, fc: 1'b0,
                   tag: "rst_async"});
    chk();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, 0, 0, 0, "rst_after");

`ifdef DOWN_COUNTER_STICKY_EN
    cyc(1, 2, 1, 0, 2, 1, 0, "stk_load", 1, 0);
    cyc(0, 0, 1, 0, 1, 1, 0, "stk_dec", 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 1, "stk_set", 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, "stk_hold", 1, 1);
    cyc(1, 1, 0, 0, 1, 1, 0, "stk_load1", 1, 1);
    done_clr = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 1, "stk_setwins", 1, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, "stk_clr", 1, 0);
    done_clr = 1'b0;
    cyc(0, 0, 1, 0, 0, 0, 0, "stk_clr_hold", 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
